// File: rtl/add_acc.sv
// add_acc: streaming accumulator. Sums LEN operands accepted on a valid/ready
// input channel with a single WIDTH-bit adder (accumulator fed back), then
// holds the total on a valid/ready output channel until it is consumed.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   clear               synchronous abort, drops partial sum / pending result
//   in_valid/in_ready   operand handshake, in_data = operand
//   out_valid/out_ready result handshake
//   out_sum             accumulated sum (mirrors the accumulator)
//   out_carry           sticky carry-out seen during this accumulation
//   out_count           operands accepted in the current accumulation
//
// Optional build macro ADD_ACC_SATURATE_EN: a beat producing a carry-out
// saturates the accumulator to all-ones instead of wrapping modulo 2^WIDTH.
module add_acc #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned LEN   = 4,
  localparam int unsigned CNT_W = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  state_e           state_q, state_n;
  logic [WIDTH-1:0] acc_n;
  logic             carry_n;
  logic [CNT_W-1:0] count_n;
  logic             in_ready_n;
  logic             out_valid_n;
  logic [WIDTH:0]   sum_w;

  // Single WIDTH+1 bit adder; top bit is the carry-out of this beat.
  assign sum_w = {1'b0, out_sum} + {1'b0, in_data};

  // Next-state and next-output decode; clear overrides everything.
  always_comb begin
    state_n     = state_q;
    acc_n       = out_sum;
    carry_n     = out_carry;
    count_n     = out_count;
    in_ready_n  = in_ready;
    out_valid_n = out_valid;

    if (clear) begin
      state_n     = ST_ACC;
      acc_n       = '0;
      carry_n     = 1'b0;
      count_n     = '0;
      in_ready_n  = 1'b1;
      out_valid_n = 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (in_valid) begin
`ifdef ADD_ACC_SATURATE_EN
            acc_n = sum_w[WIDTH] ? '1 : sum_w[WIDTH-1:0];
`else
            acc_n = sum_w[WIDTH-1:0];
`endif
            carry_n = out_carry | sum_w[WIDTH];
            count_n = out_count + CNT_W'(1);
            if (out_count == LAST_CNT) begin
              state_n     = ST_DONE;
              in_ready_n  = 1'b0;
              out_valid_n = 1'b1;
            end
          end
        end
        ST_DONE: begin
          // Result held stable until consumed; input ignored here.
          if (out_ready) begin
            state_n     = ST_ACC;
            acc_n       = '0;
            carry_n     = 1'b0;
            count_n     = '0;
            in_ready_n  = 1'b1;
            out_valid_n = 1'b0;
          end
        end
        default: begin
          state_n     = ST_ACC;
          in_ready_n  = 1'b1;
          out_valid_n = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; handshake flags are flops, not decodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ACC;
      out_sum   <= '0;
      out_carry <= 1'b0;
      out_count <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_n;
      out_sum   <= acc_n;
      out_carry <= carry_n;
      out_count <= count_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
    end
  end

endmodule
